// File: rtl/uart_wb_master.sv
// uart_wb_master: byte-command to Wishbone classic initiator for the UART register file.
// Runs one transaction at a time, steers byte lanes from adr[1:0], and bounds each cycle with an ack timeout.
// Ports:
//   clk, wb_rst_i                : clock, synchronous active-high reset
//   cmd_valid_i/ready_o/we_i/adr_i/dat_i : command channel (valid/ready)
//   rsp_valid_o/ready_i/dat_o/err_o      : response channel (valid/ready); err = timeout
//   wb_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o, wb_dat_i, wb_ack_i : Wishbone initiator port
module uart_wb_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [7:0]            cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [7:0]            rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RSP
    } state_t;

    state_t                r_state;
    state_t                w_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt;
    logic                  r_cmd_ready;
    logic                  w_cmd_ready;
    logic                  r_cyc;
    logic                  w_cyc;
    logic                  r_we;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [3:0]            r_sel;
    logic [3:0]            w_sel;
    logic [31:0]           r_dat;
    logic [31:0]           w_dat;
    logic                  r_rsp_valid;
    logic                  w_rsp_valid;
    logic [7:0]            r_rsp_dat;
    logic [7:0]            w_rsp_dat;
    logic                  r_rsp_err;
    logic                  w_rsp_err;
    logic [7:0]            w_rd_byte;
    logic                  w_accept;

    // Lane byte picked with the latched address, so it matches wb_sel_o.
    assign w_rd_byte = wb_dat_i[{r_adr[1:0], 3'b000} +: 8];
    assign w_accept  = cmd_valid_i & r_cmd_ready;

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_sel       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_cmd_ready <= w_cmd_ready;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_sel       <= w_sel;
            r_dat       <= w_dat;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_dat   <= w_rsp_dat;
            r_rsp_err   <= w_rsp_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_cmd_ready = r_cmd_ready;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_adr       = r_adr;
        w_sel       = r_sel;
        w_dat       = r_dat;
        w_rsp_valid = r_rsp_valid;
        w_rsp_dat   = r_rsp_dat;
        w_rsp_err   = r_rsp_err;
        case (r_state)
            IDLE: begin
                // Ready rises one edge after reset release, never during reset.
                w_cmd_ready = 1'b1;
                if (w_accept) begin
                    w_cmd_ready = 1'b0;
                    w_cyc       = 1'b1;
                    w_we        = cmd_we_i;
                    w_adr       = cmd_adr_i;
                    w_sel       = 4'b0001 << cmd_adr_i[1:0];
                    w_dat       = cmd_we_i ? {4{cmd_dat_i}} : 32'h0;
                    w_cnt       = '0;
                    w_state     = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the last allowed cycle is a success.
                if (wb_ack_i) begin
                    w_cyc       = 1'b0;
                    w_rsp_err   = 1'b0;
                    w_rsp_dat   = r_we ? 8'h00 : w_rd_byte;
                    w_rsp_valid = 1'b1;
                    w_state     = RSP;
                end else if (r_cnt == LAST) begin
                    w_cyc       = 1'b0;
                    w_rsp_err   = 1'b1;
                    w_rsp_dat   = 8'h00;
                    w_rsp_valid = 1'b1;
                    w_state     = RSP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_sel_o    = r_sel;
    assign wb_dat_o    = r_dat;

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed self-checking bench for uart_wb_master.
// A scripted responder drives ack/data; a small registered UART target model is used for back-to-back.
module tb_uart_wb_master;

    logic        clk;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [4:0]  cmd_adr_i;
    logic [7:0]  cmd_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [7:0]  rsp_dat_o;
    logic        rsp_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [4:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    logic        uart_mode;
    logic        d_ack;
    logic [31:0] d_dat;
    logic        t_ack;
    logic [31:0] t_dat;
    logic [7:0]  t_lcr;

    int n_cmp;
    int n_bad;
    int stb_n;

    assign wb_ack_i = uart_mode ? t_ack : d_ack;
    assign wb_dat_i = uart_mode ? t_dat : d_dat;

    uart_wb_master #(
        .ADDR_WIDTH(5),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_adr_i  (cmd_adr_i),
        .cmd_dat_i  (cmd_dat_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART-like target: inputs registered, so ack is sampled by the master 2 edges after accept.
    // LCR lives at byte address 3 (lane 3).
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            t_ack <= 1'b0;
            t_dat <= 32'h0;
            t_lcr <= 8'h00;
        end else begin
            t_ack <= wb_cyc_o & wb_stb_o & ~t_ack;
            if (wb_cyc_o & wb_stb_o & ~t_ack) begin
                if (wb_we_o && wb_adr_o == 5'd3 && wb_sel_o[3])
                    t_lcr <= wb_dat_o[31:24];
                t_dat <= {t_lcr, 24'h0};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [4:0] adr, input logic [7:0] dat);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Drives ack on the ack_at-th BUS edge (0 = never) and counts stb-high cycles.
    task automatic run_bus(input int ack_at);
        bit done;
        done  = 1'b0;
        stb_n = 0;
        for (int i = 1; i <= 40 && !done; i++) begin
            if (wb_stb_o) stb_n++;
            d_ack = (i == ack_at);
            step();
            d_ack = 1'b0;
            if (rsp_valid_o) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL bus_wait: rsp_valid=%b after 40 cycles, required 1", rsp_valid_o);
        end
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        step();
        step();
        step();
        n_cmp++;
        if ({cmd_ready_o, rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: rdy/rv/err/cyc/stb/we=%b required 000000",
                     {cmd_ready_o, rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o});
        end
        n_cmp++;
        if ({rsp_dat_o, wb_adr_o, wb_sel_o, wb_dat_o} !== 49'h0) begin
            n_bad++;
            $display("FAIL reset_data: dat=%h adr=%h sel=%h wdat=%h required all 0",
                     rsp_dat_o, wb_adr_o, wb_sel_o, wb_dat_o);
        end
        wb_rst_i = 1'b0;
        step();
        n_cmp++;
        if (cmd_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_read_lane2();
        d_dat = 32'h11C5_2233;
        send(1'b0, 5'h0A, 8'h00);
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, cmd_ready_o} !== {3'b110, 4'b0100, 5'h0A, 1'b0}) begin
            n_bad++;
            $display("FAIL read_bus: cyc=%b stb=%b we=%b sel=%b adr=%h rdy=%b required 1 1 0 0100 0a 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, cmd_ready_o);
        end
        run_bus(2);
        n_cmp++;
        if (stb_n !== 2) begin
            n_bad++;
            $display("FAIL read_stb_len: %0d cycles required 2", stb_n);
        end
        n_cmp++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o, wb_stb_o} !== {1'b1, 1'b0, 8'hC5, 1'b0}) begin
            n_bad++;
            $display("FAIL read_rsp: valid=%b err=%b dat=%h stb=%b required 1 0 c5 0",
                     rsp_valid_o, rsp_err_o, rsp_dat_o, wb_stb_o);
        end
        consume();
        n_cmp++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL read_consume: valid=%b rdy=%b required 0 1", rsp_valid_o, cmd_ready_o);
        end
    endtask

    task automatic test_timeout();
        d_dat = 32'hFFFF_FFFF;
        send(1'b0, 5'h01, 8'h00);
        run_bus(0);
        n_cmp++;
        if (stb_n !== 15) begin
            n_bad++;
            $display("FAIL timeout_stb_len: %0d cycles required 15", stb_n);
        end
        n_cmp++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o, wb_cyc_o} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_rsp: valid=%b err=%b dat=%h cyc=%b required 1 1 00 0",
                     rsp_valid_o, rsp_err_o, rsp_dat_o, wb_cyc_o);
        end
        consume();
        d_dat = 32'h0000_7E00;
        send(1'b0, 5'h01, 8'h00);
        run_bus(15);
        n_cmp++;
        if (stb_n !== 15) begin
            n_bad++;
            $display("FAIL boundary_stb_len: %0d cycles required 15", stb_n);
        end
        n_cmp++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== {1'b1, 1'b0, 8'h7E}) begin
            n_bad++;
            $display("FAIL boundary_rsp: valid=%b err=%b dat=%h required 1 0 7e",
                     rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        consume();
    endtask

    task automatic test_write_lane3();
        send(1'b1, 5'h03, 8'h5A);
        n_cmp++;
        if ({wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o} !== {32'h5A5A_5A5A, 4'b1000, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL write_bus: wdat=%h sel=%b we=%b stb=%b required 5a5a5a5a 1000 1 1",
                     wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o);
        end
        d_dat = 32'hDEAD_BEEF;
        run_bus(1);
        n_cmp++;
        if ({stb_n == 1, rsp_valid_o, rsp_err_o, rsp_dat_o} !== {3'b110, 8'h00}) begin
            n_bad++;
            $display("FAIL write_rsp: stb_len=%0d valid=%b err=%b dat=%h required 1 1 0 00",
                     stb_n, rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        n_cmp++;
        if ({wb_we_o, wb_sel_o, wb_dat_o} !== {1'b1, 4'b1000, 32'h5A5A_5A5A}) begin
            n_bad++;
            $display("FAIL write_hold: we=%b sel=%b wdat=%h required 1 1000 5a5a5a5a",
                     wb_we_o, wb_sel_o, wb_dat_o);
        end
        consume();
    endtask

    task automatic test_backpressure();
        d_dat = 32'h0000_00A7;
        send(1'b0, 5'h00, 8'h00);
        run_bus(1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 5'h02;
        cmd_dat_i   = 8'h33;
        for (int j = 0; j < 10; j++) begin
            d_ack = (j == 4);
            step();
            d_ack = 1'b0;
            n_cmp++;
            if ({rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o, wb_stb_o} !== {2'b10, 8'hA7, 2'b00}) begin
                n_bad++;
                $display("FAIL hold_%0d: valid=%b err=%b dat=%h rdy=%b stb=%b required 1 0 a7 0 0",
                         j, rsp_valid_o, rsp_err_o, rsp_dat_o, cmd_ready_o, wb_stb_o);
            end
        end
        cmd_valid_i = 1'b0;
        consume();
        n_cmp++;
        if ({cmd_ready_o, rsp_valid_o, wb_stb_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL release: rdy=%b valid=%b stb=%b required 1 0 0",
                     cmd_ready_o, rsp_valid_o, wb_stb_o);
        end
        d_ack = 1'b1;
        step();
        d_ack = 1'b0;
        step();
        n_cmp++;
        if ({cmd_ready_o, rsp_valid_o, wb_stb_o, rsp_dat_o} !== {3'b100, 8'hA7}) begin
            n_bad++;
            $display("FAIL stray_idle: rdy=%b valid=%b stb=%b dat=%h required 1 0 0 a7",
                     cmd_ready_o, rsp_valid_o, wb_stb_o, rsp_dat_o);
        end
    endtask

    task automatic test_reset_mid();
        send(1'b0, 5'h04, 8'h00);
        step();
        wb_rst_i = 1'b1;
        step();
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midreset: cyc=%b stb=%b valid=%b rdy=%b required 0 0 0 0",
                     wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o);
        end
        wb_rst_i = 1'b0;
        step();
        n_cmp++;
        if ({cmd_ready_o, rsp_valid_o, wb_stb_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL midreset_release: rdy=%b valid=%b stb=%b required 1 0 0",
                     cmd_ready_o, rsp_valid_o, wb_stb_o);
        end
        d_dat = 32'h0000_3C00;
        send(1'b0, 5'h05, 8'h00);
        run_bus(2);
        n_cmp++;
        if ({stb_n == 2, rsp_valid_o, rsp_err_o, rsp_dat_o} !== {3'b110, 8'h3C}) begin
            n_bad++;
            $display("FAIL midreset_read: stb_len=%0d valid=%b err=%b dat=%h required 2 1 0 3c",
                     stb_n, rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int acc[2];
        logic [7:0] rdat[2];
        logic rerr[2];
        int na;
        int nr;
        na = 0;
        nr = 0;
        acc[0] = 0;
        acc[1] = 0;
        rdat[0] = 8'hFF;
        rdat[1] = 8'hFF;
        rerr[0] = 1'b1;
        rerr[1] = 1'b1;
        uart_mode   = 1'b1;
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 5'h03;
        cmd_dat_i   = 8'h83;
        for (int i = 0; i < 40 && nr < 2; i++) begin
            if (cmd_valid_i && cmd_ready_o && na < 2) begin
                acc[na] = i;
                na++;
            end
            step();
            if (na == 1) begin
                cmd_we_i  = 1'b0;
                cmd_dat_i = 8'h00;
            end
            if (na == 2) cmd_valid_i = 1'b0;
            if (rsp_valid_o) begin
                rdat[nr] = rsp_dat_o;
                rerr[nr] = rsp_err_o;
                nr++;
            end
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        n_cmp++;
        if (nr !== 2 || na !== 2) begin
            n_bad++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d required 2 2", na, nr);
        end
        n_cmp++;
        if (acc[1] - acc[0] !== 4) begin
            n_bad++;
            $display("FAIL b2b_spacing: %0d cycles required 4", acc[1] - acc[0]);
        end
        n_cmp++;
        if ({rdat[0], rerr[0], rdat[1], rerr[1]} !== {8'h00, 1'b0, 8'h83, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_data: wr=%h/%b rd=%h/%b required 00/0 83/0",
                     rdat[0], rerr[0], rdat[1], rerr[1]);
        end
        uart_mode = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        stb_n       = 0;
        uart_mode   = 1'b0;
        d_ack       = 1'b0;
        d_dat       = 32'h0;
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 5'h00;
        cmd_dat_i   = 8'h00;
        rsp_ready_i = 1'b0;
        test_reset();
        test_read_lane2();
        test_timeout();
        test_write_lane3();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
